// File: rtl/stopwatch_ctrl.sv
// Stopwatch control FSM: run/stop/lap/clear sequencing, tick prescaler for the BCD counter
// chain, and a lap-freeze display mux.
module stopwatch_ctrl #(
  parameter int unsigned TICK_DIV = 100000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        btn_run,
  input  logic        btn_clear,
  input  logic        btn_lap,
  input  logic [31:0] watch_data,
  output logic        tc_cnt,
  output logic        cnt_clear,
  output logic [31:0] disp_data,
  output logic [1:0]  state
);

  localparam int unsigned PrescW = $clog2(TICK_DIV);
  localparam logic [PrescW-1:0] PrescMax = PrescW'(TICK_DIV - 1);

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StStop = 2'd2,
    StLap  = 2'd3
  } state_e;

  state_e            state_q, state_d;
  logic [PrescW-1:0] presc_q, presc_d;
  logic [31:0]       lap_q, lap_d;
  logic              clr_q, clr_d;
  logic              running;
  logic              presc_wrap;

  assign running    = (state_q == StRun) || (state_q == StLap);
  assign presc_wrap = (presc_q == PrescMax);

  always_comb begin
    state_d = state_q;
    lap_d   = lap_q;
    clr_d   = 1'b0;
    presc_d = presc_q;

    unique case (state_q)
      StIdle: begin
        if (btn_run) state_d = StRun;
      end
      StRun: begin
        if (btn_run) begin
          state_d = StStop;
        end else if (btn_lap) begin
          state_d = StLap;
          lap_d   = watch_data;
        end
      end
      StLap: begin
        if (btn_run) state_d = StStop;
        else if (btn_lap) state_d = StRun;
      end
      StStop: begin
        if (btn_clear) begin
          state_d = StIdle;
          clr_d   = 1'b1;
        end else if (btn_run) begin
          state_d = StRun;
        end
      end
      default: state_d = StIdle;
    endcase

    // Prescaler only advances while time is running; a clear from STOP restarts the phase.
    if (running) begin
      presc_d = presc_wrap ? '0 : presc_q + 1'b1;
    end else if (state_q == StStop && btn_clear) begin
      presc_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      presc_q <= '0;
      lap_q   <= '0;
      clr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      presc_q <= presc_d;
      lap_q   <= lap_d;
      clr_q   <= clr_d;
    end
  end

  // Reset suppresses the tick and holds the chain cleared in the same cycle.
  assign tc_cnt    = running && presc_wrap && !reset;
  assign cnt_clear = reset || clr_q;
  assign disp_data = (state_q == StLap) ? lap_q : watch_data;
  assign state     = state_q;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Scoreboard bench for stopwatch_ctrl: directed scenarios then random button traffic, checked
// against a cycle-count reference model.
module tb_stopwatch_ctrl;

  localparam int unsigned TD = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        btn_run = 1'b0;
  logic        btn_clear = 1'b0;
  logic        btn_lap = 1'b0;
  logic [31:0] watch_data = 32'h0;
  logic        tc_cnt;
  logic        cnt_clear;
  logic [31:0] disp_data;
  logic [1:0]  state;

  stopwatch_ctrl #(.TICK_DIV(TD)) dut (
    .clk        (clk),
    .reset      (reset),
    .btn_run    (btn_run),
    .btn_clear  (btn_clear),
    .btn_lap    (btn_lap),
    .watch_data (watch_data),
    .tc_cnt     (tc_cnt),
    .cnt_clear  (cnt_clear),
    .disp_data  (disp_data),
    .state      (state)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0]  st;
    logic        tc;
    logic        clr;
    logic [31:0] disp;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model: state plus number of running cycles since the last clear/reset.
  int          m_state = 0;
  int unsigned m_active = 0;
  logic [31:0] m_lap = 32'h0;
  bit          m_clrp = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cyc(input logic r, input logic ru, input logic cl, input logic lp,
                     input logic [31:0] w);
    exp_t e;
    @(posedge clk);
    #1;
    reset = r; btn_run = ru; btn_clear = cl; btn_lap = lp; watch_data = w;
    e.st   = 2'(m_state);
    e.tc   = !r && (m_state == 1 || m_state == 3) && (m_active % TD == TD - 1);
    e.clr  = r || m_clrp;
    e.disp = (m_state == 3) ? m_lap : w;
    sb_q.push_back(e);
    if (r) begin
      m_state = 0; m_active = 0; m_lap = 32'h0; m_clrp = 1'b0;
    end else begin
      m_clrp = (m_state == 2) && cl;
      if (m_state == 1 || m_state == 3) m_active++;
      case (m_state)
        0: if (ru) m_state = 1;
        1: if (ru) m_state = 2;
           else if (lp) begin m_state = 3; m_lap = w; end
        3: if (ru) m_state = 2;
           else if (lp) m_state = 1;
        2: if (cl) begin m_state = 0; m_active = 0; end
           else if (ru) m_state = 1;
        default: m_state = 0;
      endcase
    end
  endtask

  // Monitor: one expected record per cycle, compared mid-cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        chk("state", 32'(state), 32'(e.st));
        chk("tc_cnt", 32'(tc_cnt), 32'(e.tc));
        chk("cnt_clear", 32'(cnt_clear), 32'(e.clr));
        chk("disp_data", disp_data, e.disp);
        chk("tc_clr_excl", 32'(tc_cnt & cnt_clear), 32'h0);
      end
    end
  end

  logic [31:0] w;

  initial begin
    w = 32'h0;
    repeat (3) cyc(1'b1, 1'b0, 1'b0, 1'b0, w);

    // Ticks on the 4th, 8th, 12th running cycles.
    cyc(1'b0, 1'b1, 1'b0, 1'b0, w);
    for (int i = 1; i <= 12; i++) begin
      cyc(1'b0, 1'b0, 1'b0, 1'b0, w);
      @(negedge clk);
      chk("run_tick", 32'(tc_cnt), 32'((i % 4) == 0));
    end
    chk("run_state", 32'(state), 32'd1);

    // Pause mid-period, sit in STOP, resume.
    repeat (2) cyc(1'b0, 1'b0, 1'b0, 1'b0, w);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, w);
    for (int i = 0; i < 10; i++) begin
      cyc(1'b0, 1'b0, 1'b0, 1'b0, w);
      @(negedge clk);
      chk("stop_no_tick", 32'(tc_cnt), 32'h0);
    end
    cyc(1'b0, 1'b1, 1'b0, 1'b0, w);
    repeat (6) cyc(1'b0, 1'b0, 1'b0, 1'b0, w);

    // Lap freeze while the live value moves, then release.
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_1234);
    for (int i = 0; i < 4; i++) begin
      cyc(1'b0, 1'b0, 1'b0, 1'b0, $urandom);
      @(negedge clk);
      chk("lap_frozen", disp_data, 32'h0000_1234);
    end
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_9999);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 32'h0000_5678);
    @(negedge clk);
    chk("lap_release", disp_data, 32'h0000_5678);
    chk("lap_release_st", 32'(state), 32'd1);

    // RUN: clear ignored; run+lap together stops without capture.
    cyc(1'b0, 1'b0, 1'b1, 1'b0, w);
    cyc(1'b0, 1'b1, 1'b0, 1'b1, 32'hdead_beef);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, w);
    @(negedge clk);
    chk("runlap_state", 32'(state), 32'd2);

    // STOP: clear beats run.
    cyc(1'b0, 1'b1, 1'b1, 1'b0, w);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, w);
    @(negedge clk);
    chk("clear_state", 32'(state), 32'd0);
    chk("clear_pulse", 32'(cnt_clear), 32'd1);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, w);
    @(negedge clk);
    chk("clear_once", 32'(cnt_clear), 32'd0);

    // Reset in LAP right at the wrap point.
    cyc(1'b0, 1'b1, 1'b0, 1'b0, w);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_00aa);
    for (int i = 0; i < 8 && (m_active % TD) != TD - 1; i++) cyc(1'b0, 1'b0, 1'b0, 1'b0, w);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, w);
    @(negedge clk);
    chk("rst_no_tick", 32'(tc_cnt), 32'h0);
    chk("rst_clear", 32'(cnt_clear), 32'd1);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 32'h0000_0777);
    @(negedge clk);
    chk("rst_state", 32'(state), 32'd0);
    chk("rst_disp", disp_data, 32'h0000_0777);

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      cyc(1'($urandom_range(79) == 0), 1'($urandom_range(5) == 0),
          1'($urandom_range(4) == 0), 1'($urandom_range(4) == 0), $urandom);
    end

    cyc(1'b0, 1'b0, 1'b0, 1'b0, w);
    repeat (2) @(negedge clk);
    chk("sb_drain", 32'(sb_q.size()), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
